// File: rtl/rv_pkg.sv
// Shared RISC-V encodings for the fetch/decode front end: opcode values,
// the canonical NOP word and the fetch FSM state encoding.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register, single-outstanding imem request FSM and the
// instruction holding register presented to decode, with branch redirect.
//
// state | meaning
// IDLE  | out of reset, about to issue the first request
// REQ   | request offered on imem, address held until accepted
// WAIT  | request accepted, waiting for its single response
// HOLD  | instruction valid for decode, waiting for consume or redirect
module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(NOP_WORD)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      opcode,
    output logic [XLEN-1:0] instr_pc,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            err_misaligned
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic            drop_q, drop_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] target;

    assign target = {branch_target[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            req_addr_q    <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= RESET_PC;
            instr_valid_q <= 1'b0;
            drop_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_addr_q    <= req_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            drop_q        <= drop_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_addr_d    = req_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        drop_d        = drop_q;
        err_d         = branch_taken && (branch_target[1:0] != 2'b00);

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (branch_taken) fetch_pc_d = target;
            end
            ST_REQ: begin
                if (branch_taken) fetch_pc_d = target;
                if (imem_req_ready) begin
                    state_d = ST_WAIT;
                    drop_d  = branch_taken;
                end else if (branch_taken) begin
                    req_addr_d = target;
                end
            end
            ST_WAIT: begin
                if (branch_taken) begin
                    fetch_pc_d = target;
                    // A response in the redirect cycle is the stale one: discard it now.
                    if (imem_resp_valid) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        instr_d       = imem_resp_data;
                        instr_pc_d    = req_addr_q;
                        instr_valid_d = 1'b1;
                        fetch_pc_d    = req_addr_q + PC_STEP;
                        state_d       = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (branch_taken || instr_ready) begin
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                    state_d       = ST_REQ;
                    if (branch_taken) fetch_pc_d = target;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Every fresh request starts from the up-to-date fetch PC.
        if (state_q != ST_REQ && state_d == ST_REQ) req_addr_d = fetch_pc_d;
    end

    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_addr      = req_addr_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign opcode         = instr_q[6:0];
    assign instr_pc       = instr_pc_q;
    assign err_misaligned = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs driven and outputs checked on
// the falling edge, memory responses driven by hand.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] instr_pc;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        err_misaligned;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .opcode          (opcode),
        .instr_pc        (instr_pc),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .err_misaligned  (err_misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] held_instr;
        rst             = 1'b1;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_0000;
        instr_ready     = 1'b0;
        branch_taken    = 1'b0;
        branch_target   = '0;
        @(negedge clk);
        step();

        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_opcode", 32'(opcode), 32'h13);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_err", 32'(err_misaligned), 32'd0);

        // Release with a stray response on the bus: IDLE must ignore it.
        rst = 1'b0;
        step();
        imem_resp_valid = 1'b0;
        chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_addr", imem_addr, 32'h0);
        chk("t1_stray_resp", 32'(instr_valid), 32'd0);
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h00A0_0093;
        step();
        imem_resp_valid = 1'b0;
        chk("t1_instr_valid", 32'(instr_valid), 32'd1);
        chk("t1_instr", instr, 32'h00A0_0093);
        chk("t1_instr_pc", instr_pc, 32'h0);
        chk("t1_opcode", 32'(opcode), 32'(rv_pkg::OP_I));

        // Decode stalls: everything stays put, no new request.
        held_instr = instr;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_instr_stable", instr, held_instr);
            chk("t2_pc_stable", instr_pc, 32'h0);
            chk("t2_no_req", 32'(imem_req_valid), 32'd0);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("t2_valid_drop", 32'(instr_valid), 32'd0);
        chk("t2_instr_nop", instr, 32'h0000_0013);
        chk("t2_next_addr", imem_addr, 32'h4);
        chk("t2_req_valid", 32'(imem_req_valid), 32'd1);

        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0020_8133;
        step();
        imem_resp_valid = 1'b0;
        chk("t2b_pc", instr_pc, 32'h4);
        chk("t2b_opcode", 32'(opcode), 32'(rv_pkg::OP_R));
        instr_ready = 1'b1;
        step();
        instr_ready    = 1'b0;
        imem_req_ready = 1'b0;

        // Memory back-pressure: request must hold address 8.
        for (int i = 0; i < 3; i++) begin
            chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
            chk("t3_addr", imem_addr, 32'h8);
            step();
        end
        imem_req_ready = 1'b1;
        step();

        // Redirect while waiting; response two cycles later is stale.
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        step();
        branch_taken = 1'b0;
        chk("t4_err_aligned", 32'(err_misaligned), 32'd0);
        chk("t4_no_req_in_wait", 32'(imem_req_valid), 32'd0);
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        step();
        imem_resp_valid = 1'b0;
        chk("t4_dropped", 32'(instr_valid), 32'd0);
        chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t4_addr", imem_addr, 32'h100);
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_2083;
        step();
        imem_resp_valid = 1'b0;
        chk("t4_pc", instr_pc, 32'h100);
        chk("t4_opcode", 32'(opcode), 32'(rv_pkg::OP_LOAD));

        // Misaligned redirect from HOLD.
        branch_taken  = 1'b1;
        branch_target = 32'h102;
        step();
        branch_taken = 1'b0;
        chk("t5_valid_drop", 32'(instr_valid), 32'd0);
        chk("t5_instr_nop", instr, 32'h0000_0013);
        chk("t5_err", 32'(err_misaligned), 32'd1);
        chk("t5_addr", imem_addr, 32'h100);
        step();
        chk("t5_err_once", 32'(err_misaligned), 32'd0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0011_2023;
        step();
        imem_resp_valid = 1'b0;
        chk("t5_opcode", 32'(opcode), 32'(rv_pkg::OP_STORE));

        // PC wrap at the top of the address space.
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        branch_taken = 1'b0;
        chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0000_0063;
        step();
        imem_resp_valid = 1'b0;
        chk("t6_pc_top", instr_pc, 32'hFFFF_FFFC);
        chk("t6_opcode", 32'(opcode), 32'(rv_pkg::OP_BRANCH));
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("t6_wrap_addr", imem_addr, 32'h0);

        // Redirect of an unaccepted request, then of an accepted one.
        imem_req_ready = 1'b0;
        branch_taken   = 1'b1;
        branch_target  = 32'h200;
        step();
        chk("t7_retarget", imem_addr, 32'h200);
        chk("t7_req_valid", 32'(imem_req_valid), 32'd1);
        imem_req_ready = 1'b1;
        branch_target  = 32'h300;
        step();
        branch_taken    = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1234_5678;
        step();
        imem_resp_valid = 1'b0;
        chk("t7_dropped", 32'(instr_valid), 32'd0);
        chk("t7_addr", imem_addr, 32'h300);
        step();

        // Asynchronous reset in WAIT, checked before any clock edge.
        rst = 1'b1;
        #1;
        chk("t8_async_pc", instr_pc, 32'h0);
        chk("t8_async_req", 32'(imem_req_valid), 32'd0);
        chk("t8_async_addr", imem_addr, 32'h0);
        chk("t8_async_instr", instr, 32'h0000_0013);
        @(negedge clk);
        imem_resp_valid = 1'b1;
        step();
        rst = 1'b0;
        step();
        imem_resp_valid = 1'b0;
        chk("t8_restart_addr", imem_addr, 32'h0);
        chk("t8_restart_valid", 32'(instr_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
